pn_result_bcd: RTL and testbench

Downstream stage of the Polish Notation evaluator. It captures the evaluator's signed 32-bit result burst (out_valid/out, up to 4 back-to-back results) into a small FIFO. It converts each result to sign plus 10 BCD digits using iterative shift-add-3 (double dabble). Converted results are presented to the display/report logic over a valid/ready handshake.

---
 rtl/pn_result_bcd.sv | 204 ++++++++++++++++++++
 tb/tb_pn_result_bcd.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pn_result_bcd.sv
// pn_result_bcd
// Downstream stage of the Polish Notation evaluator. Signed 32-bit results
// arriving as a strobe burst are buffered in a small FIFO. Each result is
// then converted to sign plus 10 BCD digits by iterative shift-add-3
// (double dabble) and offered to the display/report logic over valid/ready.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      synchronous active-low reset
//   in_valid   result strobe, one result per high cycle, no backpressure
//   in_data    signed 32-bit result (two's complement)
//   out_valid  converted result available
//   out_ready  consumer accepts when out_valid && out_ready
//   out_neg    1 = result was negative
//   out_bcd    magnitude as 10 BCD digits, [39:36] most significant
//   out_ndig   significant digit count, 1..10 (zero counts as one digit)
//   ovf        sticky: a result was dropped because the FIFO was full
//   busy       FIFO non-empty or converter not idle
//
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.

module pn_result_bcd #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_neg,
   output logic [39:0] out_bcd,
   output logic [3:0]  out_ndig,
   output logic        ovf,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] OUT   = 2'd2;

   logic [31:0]   fifoMem [DEPTH];
   logic [AW-1:0] wrPtr_q;
   logic [AW-1:0] rdPtr_q;
   logic [AW:0]   count_q;

   logic [1:0]    state_q;
   logic [1:0]    state_d;
   logic          neg_q;
   logic [31:0]   mag_q;
   logic [39:0]   bcd_q;
   logic [4:0]    shCnt_q;

   logic          outValid_q;
   logic          outNeg_q;
   logic [39:0]   outBcd_q;
   logic [3:0]    outNdig_q;
   logic          ovf_q;

   logic          pop;
   logic          full;
   logic          push;
   logic          drop;
   logic [31:0]   headData;
   logic [31:0]   headMag;
   logic [39:0]   bcdAdj;
   logic [39:0]   bcdShift;
   logic [3:0]    ndig;
   logic          lastShift;

   // FIFO control. A pop only happens when the idle converter picks up the
   // head entry, so a push into a full FIFO is still accepted when that pop
   // frees a slot in the same cycle.
   always_comb begin
      pop      = (state_q == IDLE) && (count_q != '0);
      full     = (count_q == FULL_CNT);
      push     = in_valid && (!full || pop);
      drop     = in_valid && full && !pop;
      headData = fifoMem[rdPtr_q];
      headMag  = headData[31] ? (~headData + 32'd1) : headData;
   end

   // One double-dabble step: correct every digit that would overflow past 9
   // when doubled, then shift the next magnitude bit into the BCD field.
   always_comb begin
      bcdAdj = bcd_q;
      for (int i = 0; i < 10; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      bcdShift  = {bcdAdj[38:0], mag_q[31]};
      lastShift = (shCnt_q == 5'd31);
   end

   // Digit count of the final BCD value: position of the highest non-zero
   // nibble, with an all-zero value still reported as one digit.
   always_comb begin
      ndig = 4'd1;
      for (int i = 0; i < 10; i++) begin
         if (bcdShift[4*i +: 4] != 4'd0) begin
            ndig = 4'(i + 1);
         end
      end
   end

   // Converter sequencing: pick up a result, run exactly 32 shift steps,
   // then hold the converted result until the consumer takes it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pop) state_d = SHIFT;
         SHIFT:   if (lastShift) state_d = OUT;
         OUT:     if (outValid_q && out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FIFO storage has no reset; the pointers and count alone decide which
   // entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem[wrPtr_q] <= in_data;
      end
   end

   // Pointer/count bookkeeping and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
         if (drop) ovf_q <= 1'b1;
      end
   end

   // Conversion datapath and output registers. The out_* fields are only
   // written when a conversion completes, so they keep their last value
   // while out_valid is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         neg_q      <= 1'b0;
         mag_q      <= '0;
         bcd_q      <= '0;
         shCnt_q    <= '0;
         outValid_q <= 1'b0;
         outNeg_q   <= 1'b0;
         outBcd_q   <= '0;
         outNdig_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  neg_q   <= headData[31];
                  mag_q   <= headMag;
                  bcd_q   <= '0;
                  shCnt_q <= '0;
               end
            end
            SHIFT: begin
               bcd_q   <= bcdShift;
               mag_q   <= {mag_q[30:0], 1'b0};
               shCnt_q <= shCnt_q + 5'd1;
               if (lastShift) begin
                  outValid_q <= 1'b1;
                  outNeg_q   <= neg_q;
                  outBcd_q   <= bcdShift;
                  outNdig_q  <= ndig;
               end
            end
            OUT: begin
               if (outValid_q && out_ready) begin
                  outValid_q <= 1'b0;
               end
            end
            default: begin
               outValid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = outValid_q;
   assign out_neg   = outNeg_q;
   assign out_bcd   = outBcd_q;
   assign out_ndig  = outNdig_q;
   assign ovf       = ovf_q;
   assign busy      = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_pn_result_bcd.sv
// tb_pn_result_bcd
// Directed bench for pn_result_bcd. Inputs change 1 time unit after a rising
// edge; outputs are observed at that same point, after the edge has settled.
// The cycle in which a strobe is driven is cycle 0 of that strobe.

module tb_pn_result_bcd;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_neg;
   logic [39:0] out_bcd;
   logic [3:0]  out_ndig;
   logic        ovf;
   logic        busy;

   int checks;
   int failures;
   int cyc;

   pn_result_bcd #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_neg   (out_neg),
      .out_bcd   (out_bcd),
      .out_ndig  (out_ndig),
      .ovf       (ovf),
      .busy      (busy)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Single comparison with failure accounting.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks all converted-result fields at once.
   task automatic checkResult(input string tag, input logic neg, input logic [39:0] bcd, input logic [3:0] nd);
      checkOutput({tag, ".neg"},  64'(out_neg),  64'(neg));
      checkOutput({tag, ".bcd"},  64'(out_bcd),  64'(bcd));
      checkOutput({tag, ".ndig"}, 64'(out_ndig), 64'(nd));
   endtask

   // One-cycle strobe of a result value.
   task automatic applyStimulus(input logic [31:0] value);
      in_valid = 1'b1;
      in_data  = value;
      tick();
      in_valid = 1'b0;
   endtask

   // Waits (bounded) for out_valid; returns the cycle it was first seen.
   task automatic waitValid(input string tag, output int seenAt);
      int guard;
      guard = 0;
      while (!out_valid && guard < 300) begin
         tick();
         guard++;
      end
      checkOutput({tag, ".valid_timeout"}, 64'(out_valid), 64'd1);
      seenAt = cyc;
   endtask

   // Single accept: ready for one edge, then confirm valid dropped.
   task automatic acceptOne(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput({tag, ".valid_after_accept"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int t0;
      int tSeen;
      int tPrev;
      int sawValid;
      logic [31:0] burstVals [4];
      logic [39:0] burstBcd  [4];
      logic [3:0]  burstNd   [4];
      logic        burstNeg  [4];

      checks    = 0;
      failures  = 0;
      cyc       = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state.
      tick(); tick(); tick();
      checkOutput("rst.out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst.busy",      64'(busy),      64'd0);
      checkOutput("rst.ovf",       64'(ovf),       64'd0);
      checkOutput("rst.out_bcd",   64'(out_bcd),   64'd0);
      checkOutput("rst.out_ndig",  64'(out_ndig),  64'd0);
      checkOutput("rst.out_neg",   64'(out_neg),   64'd0);
      rst_n = 1'b1;
      tick();

      // Zero value and first-result latency.
      t0 = cyc;
      applyStimulus(32'd0);
      checkOutput("zero.busy", 64'(busy), 64'd1);
      waitValid("zero", tSeen);
      checkOutput("zero.latency", 64'(tSeen - t0), 64'd34);
      checkResult("zero", 1'b0, 40'h0, 4'd1);
      checkOutput("zero.ovf", 64'(ovf), 64'd0);
      acceptOne("zero");

      // Extremes of the signed range.
      applyStimulus(32'h8000_0000);
      waitValid("minint", tSeen);
      checkResult("minint", 1'b1, 40'h2147483648, 4'd10);
      acceptOne("minint");
      applyStimulus(32'h7FFF_FFFF);
      waitValid("maxint", tSeen);
      checkResult("maxint", 1'b0, 40'h2147483647, 4'd10);
      acceptOne("maxint");
      tick();

      // Burst of four on consecutive cycles with the consumer always ready.
      burstVals[0] = 32'd5;    burstBcd[0] = 40'h5;   burstNd[0] = 4'd1; burstNeg[0] = 1'b0;
      burstVals[1] = -32'sd12; burstBcd[1] = 40'h12;  burstNd[1] = 4'd2; burstNeg[1] = 1'b1;
      burstVals[2] = 32'd300;  burstBcd[2] = 40'h300; burstNd[2] = 4'd3; burstNeg[2] = 1'b0;
      burstVals[3] = 32'd7;    burstBcd[3] = 40'h7;   burstNd[3] = 4'd1; burstNeg[3] = 1'b0;
      out_ready = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = burstVals[i];
         tick();
      end
      in_valid = 1'b0;
      tPrev = t0;
      for (int i = 0; i < 4; i++) begin
         waitValid($sformatf("burst%0d", i), tSeen);
         checkOutput($sformatf("burst%0d.spacing", i), 64'(tSeen - tPrev), 64'd34);
         checkResult($sformatf("burst%0d", i), burstNeg[i], burstBcd[i], burstNd[i]);
         tPrev = tSeen;
         tick();
      end
      checkOutput("burst.ovf",       64'(ovf),       64'd0);
      checkOutput("burst.busy_end",  64'(busy),      64'd0);
      checkOutput("burst.valid_end", 64'(out_valid), 64'd0);
      out_ready = 1'b0;
      tick();

      // Stalled consumer holds -999; meanwhile five results arrive and the
      // fifth cannot fit because nothing is popped during the stall.
      applyStimulus(-32'sd999);
      waitValid("stall", tSeen);
      checkResult("stall.first", 1'b1, 40'h999, 4'd3);
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         tick();
         if (i == 4) checkOutput("ovf.after4", 64'(ovf), 64'd0);
      end
      in_valid = 1'b0;
      checkOutput("ovf.after5", 64'(ovf), 64'd1);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("stall.valid_held", 64'(out_valid), 64'd1);
      checkResult("stall.held", 1'b1, 40'h999, 4'd3);
      acceptOne("stall");
      for (int i = 1; i <= 4; i++) begin
         waitValid($sformatf("ovfout%0d", i), tSeen);
         checkResult($sformatf("ovfout%0d", i), 1'b0, 40'(i), 4'd1);
         acceptOne($sformatf("ovfout%0d", i));
      end
      sawValid = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (out_valid) sawValid = 1;
      end
      checkOutput("ovf.no_fifth", 64'(sawValid), 64'd0);
      checkOutput("ovf.sticky",   64'(ovf),      64'd1);
      checkOutput("ovf.busy_end", 64'(busy),     64'd0);

      // Reset in the middle of a conversion discards everything.
      applyStimulus(32'd123);
      applyStimulus(32'd456);
      for (int i = 0; i < 8; i++) tick();
      checkOutput("midrst.busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("midrst.out_valid", 64'(out_valid), 64'd0);
      checkOutput("midrst.out_bcd",   64'(out_bcd),   64'd0);
      checkOutput("midrst.out_ndig",  64'(out_ndig),  64'd0);
      checkOutput("midrst.out_neg",   64'(out_neg),   64'd0);
      checkOutput("midrst.ovf",       64'(ovf),       64'd0);
      checkOutput("midrst.busy",      64'(busy),      64'd0);
      sawValid = 0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (out_valid || busy) sawValid = 1;
      end
      checkOutput("midrst.quiet", 64'(sawValid), 64'd0);
      t0 = cyc;
      applyStimulus(32'd8);
      waitValid("post", tSeen);
      checkOutput("post.latency", 64'(tSeen - t0), 64'd34);
      checkResult("post", 1'b0, 40'h8, 4'd1);
      acceptOne("post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
